// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types and constants for the DLX pipeline hazard sequencer:
//          FSM state encoding, latch-control bundle and register-zero constant.
//          Optional feature macro used by the block: PIPE_STEP_EN.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Sequencer states, encoding is fixed so debug taps read consistently
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic       CTRL_NOP = 1'b0;
    localparam int         DRAIN_W  = 4;

    // One bundle for every pipeline-latch control pin
    typedef struct packed {
        logic pc_enable;
        logic if_id_enable;
        logic if_id_flush;
        logic id_ex_enable;
        logic id_ex_flush;
        logic ex_mem_enable;
        logic mem_wb_enable;
    } latch_ctrl_t;

    // All enables driven to en, both flushes driven to fl
    function automatic latch_ctrl_t ctrl_uniform(input logic en, input logic fl);
        latch_ctrl_t c;
        c.pc_enable     = en;
        c.if_id_enable  = en;
        c.if_id_flush   = fl;
        c.id_ex_enable  = en;
        c.id_ex_flush   = fl;
        c.ex_mem_enable = en;
        c.mem_wb_enable = en;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : Bundle between the DLX core datapath (master) and the hazard
//          sequencer (slave). step_req exists only with PIPE_STEP_EN.
// Rev    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_halt;
    logic [4:0]       ex_rt;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_ready;
    logic             resume;
`ifdef PIPE_STEP_EN
    logic             step_req;
`endif
    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_enable;
    logic             id_ex_flush;
    logic             ex_mem_enable;
    logic             mem_wb_enable;
    logic [CNT_W-1:0] stall_count;
    logic             halted;

    modport master (
`ifdef PIPE_STEP_EN
        output step_req,
`endif
        output id_rs, id_rt, id_uses_rt, id_halt, ex_rt, ex_mem_read,
               ex_branch_taken, mem_ready, resume,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_enable,
               id_ex_flush, ex_mem_enable, mem_wb_enable, stall_count, halted
    );

    modport slave (
`ifdef PIPE_STEP_EN
        input  step_req,
`endif
        input  id_rs, id_rt, id_uses_rt, id_halt, ex_rt, ex_mem_read,
               ex_branch_taken, mem_ready, resume,
        output pc_enable, if_id_enable, if_id_flush, id_ex_enable,
               id_ex_flush, ex_mem_enable, mem_wb_enable, stall_count, halted
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module : load_use_detect
// Brief  : Flags a load in EX whose destination is a source of the
//          instruction in ID. Writes to r0 never create a hazard.
// Rev    : 1.0  initial release
// ============================================================================
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  wire logic [4:0] id_rs,
    input  wire logic [4:0] id_rt,
    input  wire logic       id_uses_rt,
    input  wire logic [4:0] ex_rt,
    input  wire logic       ex_mem_read,
    output logic            load_use
);
    logic w_rs_match;
    logic w_rt_match;

    // Source-register comparison against the load destination
    always_comb begin
        w_rs_match = (ex_rt == id_rs);
        w_rt_match = id_uses_rt && (ex_rt == id_rt);
        load_use   = ex_mem_read && (ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);
    end
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Pipeline sequencer for the 5-stage DLX core. Generates the
//          enable/flush pins of IF_ID, ID_EX, EX_MEM and MEM_WB: load-use
//          bubbles, branch squash, memory-wait freeze and HALT drain/stop.
//          Optional feature: define PIPE_STEP_EN for single-step out of HALT.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [DRAIN_W-1:0] c_drain_load = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);

    state_t             r_state;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0]   r_stall_count;
    latch_ctrl_t        w_ctrl;
    logic               w_halted;
    logic               w_load_use;

    load_use_detect u_load_use_detect (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_rt       (bus.ex_rt),
        .ex_mem_read (bus.ex_mem_read),
        .load_use    (w_load_use)
    );

    // Same-cycle latch control decoded from state and hazard inputs
    always_comb begin
        w_ctrl   = ctrl_uniform(CTRL_NOP, CTRL_NOP);
        w_halted = 1'b0;
        if (reset) begin
            w_ctrl = ctrl_uniform(CTRL_NOP, 1'b1);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!bus.mem_ready) begin
                        // memory wait freezes every latch; nothing else acts
                        w_ctrl = ctrl_uniform(CTRL_NOP, CTRL_NOP);
                    end else if (bus.ex_branch_taken) begin
                        // squash both wrong-path instructions behind the branch
                        w_ctrl = ctrl_uniform(1'b1, 1'b1);
                    end else if (w_load_use) begin
                        // hold IF/ID, push one bubble into EX
                        w_ctrl.id_ex_flush   = 1'b1;
                        w_ctrl.ex_mem_enable = 1'b1;
                        w_ctrl.mem_wb_enable = 1'b1;
                    end else if (bus.id_halt) begin
                        // HALT advances into EX, front end stops fetching
                        w_ctrl.id_ex_enable  = 1'b1;
                        w_ctrl.ex_mem_enable = 1'b1;
                        w_ctrl.mem_wb_enable = 1'b1;
                    end else begin
                        w_ctrl = ctrl_uniform(1'b1, CTRL_NOP);
                    end
                end
                ST_DRAIN: begin
                    w_ctrl.id_ex_flush   = 1'b1;
                    w_ctrl.ex_mem_enable = bus.mem_ready;
                    w_ctrl.mem_wb_enable = bus.mem_ready;
                end
                ST_HALT: begin
                    w_halted = 1'b1;
                    if (bus.resume) begin
                        // the parked HALT in IF_ID must not re-execute
                        w_ctrl.if_id_flush = 1'b1;
                    end
`ifdef PIPE_STEP_EN
                    else if (bus.step_req) begin
                        w_ctrl   = ctrl_uniform(1'b1, CTRL_NOP);
                        w_halted = 1'b0;
                    end
`endif
                end
                default: begin
                    w_ctrl = ctrl_uniform(CTRL_NOP, CTRL_NOP);
                end
            endcase
        end
    end

    // Sequencer state, drain countdown and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_stall_count <= '0;
        end else begin
            if (!w_ctrl.pc_enable && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + c_cnt_one;
            end
            case (r_state)
                ST_RUN: begin
                    if (bus.mem_ready && !bus.ex_branch_taken && !w_load_use && bus.id_halt) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_drain_load;
                    end
                end
                ST_DRAIN: begin
                    if (bus.mem_ready) begin
                        if (r_drain_cnt == '0) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.resume) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc_enable     = w_ctrl.pc_enable;
    assign bus.if_id_enable  = w_ctrl.if_id_enable;
    assign bus.if_id_flush   = w_ctrl.if_id_flush;
    assign bus.id_ex_enable  = w_ctrl.id_ex_enable;
    assign bus.id_ex_flush   = w_ctrl.id_ex_flush;
    assign bus.ex_mem_enable = w_ctrl.ex_mem_enable;
    assign bus.mem_wb_enable = w_ctrl.mem_wb_enable;
    assign bus.stall_count   = r_stall_count;
    assign bus.halted        = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed-vector bench for pipe_hazard_ctrl with a queue scoreboard.
//          Covers PIPE_STEP_EN when that macro is defined.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // control bit order: pc, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_en
    localparam logic [6:0] c_reset  = 7'b0010100;
    localparam logic [6:0] c_run    = 7'b1101011;
    localparam logic [6:0] c_branch = 7'b1111111;
    localparam logic [6:0] c_bubble = 7'b0000111;
    localparam logic [6:0] c_freeze = 7'b0000000;
    localparam logic [6:0] c_hdec   = 7'b0001011;
    localparam logic [6:0] c_drain  = 7'b0000111;
    localparam logic [6:0] c_drainw = 7'b0000100;
    localparam logic [6:0] c_halt   = 7'b0000000;
    localparam logic [6:0] c_resume = 7'b0010000;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       halt;
        logic [4:0] ex_rt;
        logic       mread;
        logic       br;
        logic       mr;
        logic       res;
        logic       step;
    } stim_t;

    typedef struct {
        logic [6:0]  ctrl;
        logic        halted;
        logic [31:0] stall;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_total   = 0;
    int          n_pass    = 0;
    logic [31:0] exp_stall = 32'd0;

    // Apply one cycle of stimulus and queue the response it must produce
    task automatic drive(input stim_t s, input logic [6:0] c, input logic h, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset               = s.rst;
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.id_uses_rt      = s.uses_rt;
        bus.id_halt         = s.halt;
        bus.ex_rt           = s.ex_rt;
        bus.ex_mem_read     = s.mread;
        bus.ex_branch_taken = s.br;
        bus.mem_ready       = s.mr;
        bus.resume          = s.res;
`ifdef PIPE_STEP_EN
        bus.step_req        = s.step;
`endif
        e.ctrl   = c;
        e.halted = h;
        e.stall  = exp_stall;
        e.name   = nm;
        q.push_back(e);
        if (s.rst) exp_stall = 32'd0;
        else if (!c[6]) exp_stall = exp_stall + 32'd1;
    endtask

    // Monitor: pop one expectation per cycle, compare mid-cycle
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [6:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.pc_enable, bus.if_id_enable, bus.if_id_flush, bus.id_ex_enable,
                   bus.id_ex_flush, bus.ex_mem_enable, bus.mem_wb_enable};
            n_total++;
            if (act === e.ctrl) n_pass++;
            else $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
            n_total++;
            if (bus.halted === e.halted) n_pass++;
            else $display("FAIL %s halted: got %b expected %b", e.name, bus.halted, e.halted);
            n_total++;
            if (bus.stall_count === e.stall) n_pass++;
            else $display("FAIL %s stall_count: got %0d expected %0d", e.name, bus.stall_count, e.stall);
        end
    end

    stim_t idle;
    stim_t s;

    initial begin
        idle = '{rst: 1'b0, rs: 5'd1, rt: 5'd2, uses_rt: 1'b1, halt: 1'b0, ex_rt: 5'd3,
                 mread: 1'b0, br: 1'b0, mr: 1'b1, res: 1'b0, step: 1'b0};
        reset               = 1'b1;
        bus.id_rs           = idle.rs;
        bus.id_rt           = idle.rt;
        bus.id_uses_rt      = idle.uses_rt;
        bus.id_halt         = 1'b0;
        bus.ex_rt           = idle.ex_rt;
        bus.ex_mem_read     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_ready       = 1'b1;
        bus.resume          = 1'b0;
`ifdef PIPE_STEP_EN
        bus.step_req        = 1'b0;
`endif
        @(posedge clk);

        // reset held three cycles, then idle running
        s = idle; s.rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(s, c_reset, 1'b0, "reset");
        for (int i = 0; i < 2; i++) drive(idle, c_run, 1'b0, "idle_run");

        // load-use through rs, then through rt, then non-hazards
        s = idle; s.mread = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5;
        drive(s, c_bubble, 1'b0, "lu_rs");
        drive(idle, c_run, 1'b0, "after_lu");
        s = idle; s.mread = 1'b1; s.ex_rt = 5'd7; s.rt = 5'd7;
        drive(s, c_bubble, 1'b0, "lu_rt");
        s.uses_rt = 1'b0;
        drive(s, c_run, 1'b0, "rt_unused");
        s = idle; s.mread = 1'b1; s.ex_rt = 5'd0; s.rs = 5'd0;
        drive(s, c_run, 1'b0, "lu_r0");

        // branch beats a simultaneous load-use
        s = idle; s.mread = 1'b1; s.ex_rt = 5'd5; s.rs = 5'd5; s.br = 1'b1;
        drive(s, c_branch, 1'b0, "br_over_lu");

        // four memory-wait cycles, one with a taken branch underneath
        s = idle; s.mr = 1'b0;
        drive(s, c_freeze, 1'b0, "freeze");
        drive(s, c_freeze, 1'b0, "freeze");
        s.br = 1'b1;
        drive(s, c_freeze, 1'b0, "freeze_br");
        s.br = 1'b0;
        drive(s, c_freeze, 1'b0, "freeze");
        drive(idle, c_run, 1'b0, "after_freeze");

        // HALT decode, three drain cycles, halted, resume
        s = idle; s.halt = 1'b1;
        drive(s, c_hdec, 1'b0, "halt_dec");
        for (int i = 0; i < 3; i++) drive(idle, c_drain, 1'b0, "drain");
        drive(s, c_halt, 1'b1, "halted");
        drive(s, c_halt, 1'b1, "halted");
        s.res = 1'b1;
        drive(s, c_resume, 1'b1, "resume");
        drive(idle, c_run, 1'b0, "after_resume");

        // branch overrides a HALT in ID
        s = idle; s.halt = 1'b1; s.br = 1'b1;
        drive(s, c_branch, 1'b0, "br_over_halt");
        drive(idle, c_run, 1'b0, "after_br_halt");

        // drain stretched by a memory wait
        s = idle; s.halt = 1'b1;
        drive(s, c_hdec, 1'b0, "halt_dec2");
        drive(idle, c_drain, 1'b0, "drain2");
        s = idle; s.mr = 1'b0;
        drive(s, c_drainw, 1'b0, "drain_wait");
        drive(idle, c_drain, 1'b0, "drain2");
        drive(idle, c_drain, 1'b0, "drain2_last");
        drive(idle, c_halt, 1'b1, "halted2");

`ifdef PIPE_STEP_EN
        // single step with a HALT in ID: one full-enable cycle, then halted again
        s = idle; s.step = 1'b1; s.halt = 1'b1;
        drive(s, c_run, 1'b0, "step");
        drive(idle, c_halt, 1'b1, "after_step");
`endif

        // reset while halted abandons HALT and clears the counter
        s = idle; s.rst = 1'b1;
        drive(s, c_reset, 1'b0, "mid_reset");
        drive(s, c_reset, 1'b0, "mid_reset");
        drive(idle, c_run, 1'b0, "post_reset");

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain_queue: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
